// File: rtl/sram_pkg.sv
// Shared types and defaults for the synchronous SRAM macro.
package sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_OUT_REG = 0;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_array.sv
// DEPTH x DATA_W storage with byte-masked write and registered read.
module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [lane_count(DATA_W)-1:0] be,
  input  logic                          rd_en,
  input  logic                          rd_in_range,
  output logic [DATA_W-1:0]             rdata
);

  localparam int NB = lane_count(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage itself is never reset; the clear sequence in the top handles it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/sram_sync.sv
// Single-port SRAM with valid/ready requests, clear-on-reset and fixed read latency.
module sram_sync
  import sram_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int OUT_REG = DEF_OUT_REG
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [lane_count(DATA_W)-1:0] req_be,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          init_done
);

  localparam int NB = lane_count(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    case (state)
      INIT: begin
        if (clr_cnt == LAST_WORD) state_nxt = RUN;
        else                      clr_nxt   = clr_cnt + 1'b1;
      end
      RUN: ;
      default: state_nxt = INIT;
    endcase
  end

  assign req_ready = (state == RUN);
  assign init_done = (state == RUN);

  logic in_range, accept, rd_acc, wr_acc;
  assign in_range = ({1'b0, req_addr} < DEPTH_L);
  assign accept   = req_valid & req_ready;
  assign rd_acc   = accept & ~req_we;
  assign wr_acc   = accept & req_we & in_range;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [NB-1:0]     arr_be;
  logic [DATA_W-1:0] arr_rdata;

  // The clear sequence owns the write port while in INIT.
  always_comb begin
    arr_we    = wr_acc;
    arr_addr  = req_addr;
    arr_wdata = req_wdata;
    arr_be    = req_be;
    if (state == INIT) begin
      arr_we    = 1'b1;
      arr_addr  = clr_cnt;
      arr_wdata = '0;
      arr_be    = '1;
    end
  end

  sram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .we          (arr_we),
    .addr        (arr_addr),
    .wdata       (arr_wdata),
    .be          (arr_be),
    .rd_en       (rd_acc),
    .rd_in_range (in_range),
    .rdata       (arr_rdata)
  );

  logic vld1, err1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      vld1 <= rd_acc;
      err1 <= rd_acc & ~in_range;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              vld2, err2;
      logic [DATA_W-1:0] rdata2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld2   <= 1'b0;
          err2   <= 1'b0;
          rdata2 <= '0;
        end else begin
          vld2 <= vld1;
          err2 <= err1;
          if (vld1) rdata2 <= arr_rdata;
        end
      end

      assign rsp_valid = vld2;
      assign rsp_err   = err2;
      assign rsp_rdata = rdata2;
    end else begin : g_no_out_reg
      assign rsp_valid = vld1;
      assign rsp_err   = err1;
      assign rsp_rdata = arr_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_sram_sync.sv
// Scoreboard bench: two instances (DEPTH 32 / latency 1 and DEPTH 20 / latency 2) share stimulus.
module tb_sram_sync;

  typedef struct {
    logic [15:0] d;
    logic        e;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;

  logic        a_ready, a_valid, a_err, a_init;
  logic [15:0] a_rdata;
  logic        b_ready, b_valid, b_err, b_init;
  logic [15:0] b_rdata;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] ma [32];
  logic [15:0] mb [20];
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_sync #(.DATA_W(16), .ADDR_W(5), .DEPTH(32), .OUT_REG(0)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_valid), .rsp_rdata(a_rdata), .rsp_err(a_err), .init_done(a_init)
  );

  sram_sync #(.DATA_W(16), .ADDR_W(5), .DEPTH(20), .OUT_REG(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(b_valid), .rsp_rdata(b_rdata), .rsp_err(b_err), .init_done(b_init)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected response whenever an instance presents one.
  always @(negedge clk) begin
    if (a_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rsp", a_valid, 1'b0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rdata", a_rdata, e.d);
        chk("a_err", a_err, e.e);
        chk("a_latency_cycle", cyc, e.t);
      end
    end
  end

  always @(negedge clk) begin
    if (b_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rsp", b_valid, 1'b0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rdata", b_rdata, e.d);
        chk("b_err", b_err, e.e);
        chk("b_latency_cycle", cyc, e.t);
      end
    end
  end

  // Called at posedge+1; the request is accepted at the next edge.
  task automatic issue(input logic we, input logic [4:0] a, input logic [15:0] d,
                       input logic [1:0] be);
    exp_t e;
    chk("a_ready_run", a_ready, 1'b1);
    chk("b_ready_run", b_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(posedge clk);
    #1;
    if (we) begin
      for (int i = 0; i < 2; i++) begin
        if (be[i]) begin
          ma[a][8*i +: 8] = d[8*i +: 8];
          if (a < 20) mb[a][8*i +: 8] = d[8*i +: 8];
        end
      end
    end else begin
      e.d = ma[a];
      e.e = 1'b0;
      e.t = cyc;
      qa.push_back(e);
      e.d = (a < 20) ? mb[a] : 16'h0000;
      e.e = (a >= 20);
      e.t = cyc + 1;
      qb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("a_rst_valid", a_valid, 1'b0);
    chk("a_rst_rdata", a_rdata, 16'h0);
    chk("a_rst_err", a_err, 1'b0);
    chk("a_rst_ready", a_ready, 1'b0);
    chk("b_rst_valid", b_valid, 1'b0);
    chk("b_rst_rdata", b_rdata, 16'h0);
    chk("b_rst_init", b_init, 1'b0);
    qa.delete();
    qb.delete();
    for (int i = 0; i < 32; i++) ma[i] = 16'h0;
    for (int i = 0; i < 20; i++) mb[i] = 16'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle k is the interval before the k-th edge after reset release.
  task automatic init_check();
    for (int k = 0; k <= 32; k++) begin
      chk($sformatf("a_ready_c%0d", k), a_ready, (k >= 32));
      chk($sformatf("a_init_c%0d", k), a_init, (k >= 32));
      chk($sformatf("b_ready_c%0d", k), b_ready, (k >= 20));
      chk($sformatf("b_init_c%0d", k), b_init, (k >= 20));
      if (k < 32) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) issue(1'b0, 5'(i), 16'h0, 2'b00);
    idle(4);
  endtask

  task automatic drain_check(input string tag);
    idle(4);
    chk({tag, "_a_pending"}, qa.size(), 0);
    chk({tag, "_b_pending"}, qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    init_check();
    read_all();

    issue(1'b1, 5'd5, 16'hBEEF, 2'b11);
    issue(1'b0, 5'd5, 16'h0, 2'b00);
    issue(1'b0, 5'd6, 16'h0, 2'b00);
    issue(1'b1, 5'd3, 16'h1234, 2'b11);
    issue(1'b1, 5'd3, 16'hAB00, 2'b10);
    issue(1'b0, 5'd3, 16'h0, 2'b00);
    issue(1'b1, 5'd19, 16'h5A5A, 2'b11);
    issue(1'b1, 5'd25, 16'hCAFE, 2'b11);
    issue(1'b0, 5'd25, 16'h0, 2'b00);
    issue(1'b0, 5'd19, 16'h0, 2'b00);
    issue(1'b1, 5'd7, 16'h7777, 2'b00);
    issue(1'b0, 5'd7, 16'h0, 2'b00);
    idle(3);
    for (int i = 0; i < 8; i++) issue(1'b1, 5'(i), 16'(16'h1100 + i * 16'h0101), 2'b11);
    for (int i = 0; i < 8; i++) issue(1'b0, 5'(i), 16'h0, 2'b00);
    drain_check("directed");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            16'($urandom), 2'($urandom_range(0, 3)));
    end
    drain_check("random");

    for (int i = 0; i < 32; i++) issue(1'b1, 5'(i), 16'(16'hF000 | i), 2'b11);
    issue(1'b0, 5'd4, 16'h0, 2'b00);
    do_reset();
    idle(3);
    chk("mid_read_no_pulse_a", qa.size(), 0);
    chk("mid_read_no_pulse_b", qb.size(), 0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    init_check();
    read_all();
    drain_check("after_resets");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
